// File: rtl/reciprocal_arbiter.sv
// Round-robin arbiter that time-shares one combinational reciprocal unit
// between N_REQ requesters, holding the operand SETTLE cycles before capture.
module reciprocal_arbiter #(
  parameter int N_REQ  = 3,
  parameter int W      = 24,
  parameter int SETTLE = 2,
  localparam int PW    = $clog2(N_REQ),
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_data,
  input  logic [N_REQ-1:0]   i_abs,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_valid,
  output logic [W-1:0]       o_data,
  output logic               o_sat,
  output logic               o_busy,
  output logic [W-1:0]       rcp_in,
  output logic               rcp_abs,
  input  logic [W-1:0]       rcp_out,
  input  logic               rcp_sat,
  output logic [1:0]         dbg_state,
  output logic [PW-1:0]      dbg_ptr
);

  // Handshake: a requester holds i_req (level) with a stable operand until it
  // sees o_gnt; o_valid[k] is a one-cycle pulse with no back-pressure, and the
  // requester drops i_req on the edge that ends that pulse unless it wants more.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     ptr_next;
  logic [N_REQ-1:0]  win_onehot;
  logic [W-1:0]      win_data;
  int                scan;

  // First set request scanning upward from ptr, wrapping at N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = int'(ptr) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!win_found && i_req[scan]) begin
        win_found = 1'b1;
        win_idx   = PW'(scan);
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    win_data            = i_data[int'(win_idx)*W +: W];
    ptr_next            = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (win_found) state_next = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != S_IDLE);
    dbg_state = state;
    dbg_ptr   = ptr;
  end

  // o_gnt doubles as the record of which requester owns the operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_gnt   <= '0;
      o_valid <= '0;
      o_data  <= '0;
      o_sat   <= 1'b0;
      rcp_in  <= '0;
      rcp_abs <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            rcp_in  <= win_data;
            rcp_abs <= i_abs[win_idx];
            o_gnt   <= win_onehot;
            cnt     <= CW'(SETTLE - 1);
            ptr     <= ptr_next;
          end
        end
        S_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            o_data  <= rcp_out;
            o_sat   <= rcp_sat;
            o_valid <= o_gnt;
            o_gnt   <= '0;
          end
        end
        S_DONE:  o_valid <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reciprocal_arbiter.sv
// Directed bench for reciprocal_arbiter: table of single operations plus
// hand-written round-robin, operand-stability, reset and abandon sequences.
module tb_reciprocal_arbiter;

  localparam int N_REQ = 3;
  localparam int W     = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       i_req;
  logic [3*W-1:0]   i_data;
  logic [2:0]       i_abs;
  logic [2:0]       o_gnt;
  logic [2:0]       o_valid;
  logic [W-1:0]     o_data;
  logic             o_sat;
  logic             o_busy;
  logic [W-1:0]     rcp_in;
  logic             rcp_abs;
  logic [W-1:0]     rcp_out;
  logic             rcp_sat;
  logic [1:0]       dbg_state;
  logic [1:0]       dbg_ptr;

  int checks = 0;
  int errors = 0;

  reciprocal_arbiter #(.N_REQ(N_REQ), .W(W), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_data(i_data), .i_abs(i_abs),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_data(o_data), .o_sat(o_sat),
    .o_busy(o_busy), .rcp_in(rcp_in), .rcp_abs(rcp_abs), .rcp_out(rcp_out),
    .rcp_sat(rcp_sat), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  always #5 clk = ~clk;

  // Stand-in Q12.12 reciprocal: 2^24 / |x|, saturating to the max magnitude.
  logic [W-1:0] mag;
  logic         neg;
  logic [W:0]   quo;
  always_comb begin
    mag     = rcp_in[W-1] ? (~rcp_in + 24'd1) : rcp_in;
    neg     = rcp_in[W-1] && !rcp_abs;
    quo     = '0;
    rcp_sat = 1'b0;
    rcp_out = '0;
    if (mag == '0) begin
      rcp_sat = 1'b1;
      rcp_out = 24'h7FFFFF;
    end else begin
      quo = 25'h1000000 / {1'b0, mag};
      if (quo > 25'h07FFFFF) begin
        rcp_sat = 1'b1;
        rcp_out = neg ? 24'h800000 : 24'h7FFFFF;
      end else begin
        rcp_out = neg ? (~quo[W-1:0] + 24'd1) : quo[W-1:0];
      end
    end
  end

  typedef struct {
    logic [2:0]  req;
    logic [23:0] d0, d1, d2;
    logic [2:0]  abs_v;
    int          k;
    logic [23:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_valid_exclusive", {31'd0, (|o_gnt) && (|o_valid)}, 32'd0);
    chk("onehot0", {31'd0, ($countones(o_gnt) <= 1) && ($countones(o_valid) <= 1)}, 32'd1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    i_req  = '0;
    i_data = '0;
    i_abs  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [23:0] opnd;
    opnd   = (v.k == 0) ? v.d0 : (v.k == 1) ? v.d1 : v.d2;
    i_req  = v.req;
    i_data = {v.d2, v.d1, v.d0};
    i_abs  = v.abs_v;
    step();
    chk($sformatf("v%0d_gnt_c1", idx), {29'd0, o_gnt}, 32'd1 << v.k);
    chk($sformatf("v%0d_rcp_in", idx), {8'd0, rcp_in}, {8'd0, opnd});
    chk($sformatf("v%0d_ptr", idx), {30'd0, dbg_ptr}, (v.k + 1) % 3);
    chk($sformatf("v%0d_busy", idx), {31'd0, o_busy}, 32'd1);
    step();
    chk($sformatf("v%0d_gnt_c2", idx), {29'd0, o_gnt}, 32'd1 << v.k);
    chk($sformatf("v%0d_valid_c2", idx), {29'd0, o_valid}, 32'd0);
    step();
    chk($sformatf("v%0d_valid_c3", idx), {29'd0, o_valid}, 32'd1 << v.k);
    chk($sformatf("v%0d_gnt_c3", idx), {29'd0, o_gnt}, 32'd0);
    chk($sformatf("v%0d_data", idx), {8'd0, o_data}, {8'd0, v.exp_data});
    chk($sformatf("v%0d_sat", idx), {31'd0, o_sat}, {31'd0, v.exp_sat});
    i_req = '0;
    step();
    chk($sformatf("v%0d_valid_c4", idx), {29'd0, o_valid}, 32'd0);
    chk($sformatf("v%0d_busy_c4", idx), {31'd0, o_busy}, 32'd0);
  endtask

  logic [23:0] rr_exp[3];

  initial begin
    // ptr evolves 0->1->1->0->2->2->1->2->0 across these entries.
    vecs[0] = '{3'b001, 24'h002000, 24'h0,      24'h0,      3'b001, 0, 24'h000800, 1'b0};
    vecs[1] = '{3'b001, 24'h000800, 24'h0,      24'h0,      3'b000, 0, 24'h002000, 1'b0};
    vecs[2] = '{3'b101, 24'h002000, 24'h0,      24'h001000, 3'b000, 2, 24'h001000, 1'b0};
    vecs[3] = '{3'b110, 24'h0,      24'hFFE000, 24'h004000, 3'b000, 1, 24'hFFF800, 1'b0};
    vecs[4] = '{3'b010, 24'h0,      24'hFFE000, 24'h0,      3'b010, 1, 24'h000800, 1'b0};
    vecs[5] = '{3'b011, 24'h000000, 24'h002000, 24'h0,      3'b000, 0, 24'h7FFFFF, 1'b1};
    vecs[6] = '{3'b111, 24'h002000, 24'h000100, 24'h001000, 3'b000, 1, 24'h010000, 1'b0};
    vecs[7] = '{3'b111, 24'h002000, 24'h000100, 24'h003000, 3'b000, 2, 24'h000555, 1'b0};
    rr_exp[0] = 24'h000800;
    rr_exp[1] = 24'h000400;
    rr_exp[2] = 24'h001000;

    do_reset();
    chk("rst_gnt",     {29'd0, o_gnt},    32'd0);
    chk("rst_valid",   {29'd0, o_valid},  32'd0);
    chk("rst_data",    {8'd0, o_data},    32'd0);
    chk("rst_sat",     {31'd0, o_sat},    32'd0);
    chk("rst_busy",    {31'd0, o_busy},   32'd0);
    chk("rst_rcp_in",  {8'd0, rcp_in},    32'd0);
    chk("rst_rcp_abs", {31'd0, rcp_abs},  32'd0);
    chk("rst_ptr",     {30'd0, dbg_ptr},  32'd0);
    chk("rst_state",   {30'd0, dbg_state}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Continuous requests from all three: grants 0,1,2,0,1,2 every 4 cycles.
    do_reset();
    i_req  = 3'b111;
    i_data = {24'h001000, 24'h004000, 24'h002000};
    i_abs  = 3'b000;
    for (int op = 0; op < 6; op++) begin
      step();
      chk($sformatf("rr%0d_gnt", op), {29'd0, o_gnt}, 32'd1 << (op % 3));
      chk($sformatf("rr%0d_ptr", op), {30'd0, dbg_ptr}, (op % 3 + 1) % 3);
      step();
      step();
      chk($sformatf("rr%0d_valid", op), {29'd0, o_valid}, 32'd1 << (op % 3));
      chk($sformatf("rr%0d_data", op), {8'd0, o_data}, {8'd0, rr_exp[op % 3]});
      step();
      chk($sformatf("rr%0d_idle", op), {31'd0, o_busy}, 32'd0);
      chk($sformatf("rr%0d_gnt_idle", op), {29'd0, o_gnt}, 32'd0);
    end
    i_req = '0;
    step();
    step();
    chk("hold_busy",   {31'd0, o_busy}, 32'd0);
    chk("hold_data",   {8'd0, o_data},  32'h001000);
    chk("hold_rcp_in", {8'd0, rcp_in},  32'h001000);
    chk("hold_gnt",    {29'd0, o_gnt},  32'd0);

    // Operand changed after the grant edge must not affect the result.
    i_req  = 3'b010;
    i_data = {24'h0, 24'h004000, 24'h0};
    step();
    chk("stab_gnt", {29'd0, o_gnt}, 32'b010);
    i_data = {24'h0, 24'h001000, 24'h0};
    i_abs  = 3'b010;
    step();
    step();
    chk("stab_valid", {29'd0, o_valid}, 32'b010);
    chk("stab_data",  {8'd0, o_data},   32'h000400);
    chk("stab_rcp_abs", {31'd0, rcp_abs}, 32'd0);
    i_req = '0;
    i_abs = '0;
    step();

    // Reset in cycle 2 of an operation.
    i_req  = 3'b001;
    i_data = {24'h0, 24'h0, 24'h002000};
    step();
    chk("mrst_gnt_c1", {29'd0, o_gnt}, 32'b001);
    step();
    reset = 1'b1;
    step();
    chk("mrst_gnt",    {29'd0, o_gnt},   32'd0);
    chk("mrst_busy",   {31'd0, o_busy},  32'd0);
    chk("mrst_ptr",    {30'd0, dbg_ptr}, 32'd0);
    chk("mrst_valid",  {29'd0, o_valid}, 32'd0);
    chk("mrst_rcp_in", {8'd0, rcp_in},   32'd0);
    reset = 1'b0;
    i_req = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("mrst_novalid_%0d", c), {29'd0, o_valid}, 32'd0);
    end

    // Requester 2 drops its request after the grant; 0 and 1 become pending.
    i_req  = 3'b100;
    i_data = {24'h002000, 24'h004000, 24'h000100};
    step();
    chk("abn_gnt", {29'd0, o_gnt}, 32'b100);
    chk("abn_ptr", {30'd0, dbg_ptr}, 32'd0);
    i_req = 3'b011;
    step();
    step();
    chk("abn_valid", {29'd0, o_valid}, 32'b100);
    chk("abn_data",  {8'd0, o_data},   32'h000800);
    step();
    chk("abn_done_ignored", {29'd0, o_gnt}, 32'd0);
    chk("abn_idle", {31'd0, o_busy}, 32'd0);
    step();
    chk("abn_next_gnt", {29'd0, o_gnt}, 32'b001);
    step();
    step();
    chk("abn_next_valid", {29'd0, o_valid}, 32'b001);
    chk("abn_next_data",  {8'd0, o_data},   32'h010000);
    i_req = '0;
    step();
    chk("abn_end_busy", {31'd0, o_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
